forward_hazard_unit: RTL and testbench
======================================

# forward_hazard_unit

Parametrised forwarding and hazard unit for the pipelined RISC-V core, the successor of the two-operand EX forwarding logic. It produces a forwarding select per source operand for any number of operands. It detects load-use hazards and stalls for a configurable number of cycles using an internal counter/FSM. It freezes the whole pipeline while data memory is busy and keeps saturating performance counters for stall and freeze cycles. It sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers and drives their hold/bubble controls.

## Interface
- REG_AW, 5, register address width
- NSRC, 2, source operands per instruction (1..4)
- LOAD_USE_CYCLES, 1, stall cycles per load-use hazard (1..15)
- CNT_W, 16, performance counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ex_mem_regWrite  in  1  EX/MEM instruction writes rd
- ex_mem_rd  in  REG_AW  EX/MEM destination
- mem_wb_regWrite  in  1  MEM/WB instruction writes rd
- mem_wb_rd  in  REG_AW  MEM/WB destination
- id_ex_rs  in  NSRC*REG_AW  ID/EX sources; operand i at [i*REG_AW +: REG_AW]
- id_ex_memRead  in  1  ID/EX instruction is a load
- id_ex_rd  in  REG_AW  ID/EX destination
- if_id_rs  in  NSRC*REG_AW  IF/ID sources, same packing
- if_id_rs_used  in  NSRC  IF/ID operand i actually read
- flush  in  1  branch/jump taken in EX; IF/ID contents discarded
- dmem_busy  in  1  data memory not ready
- cnt_clr  in  1  synchronous clear of both counters
- fwd_sel  out  2*NSRC  operand i select at [2*i +: 2]: 10 EX/MEM, 01 MEM/WB, 00 register file
- stall  out  1  hold PC and IF/ID
- bubble  out  1  load NOP controls into ID/EX
- freeze  out  1  hold every pipeline register
- stall_cnt  out  CNT_W  cycles with stall=1, saturating
- freeze_cnt  out  CNT_W  cycles with freeze=1, saturating

## Operation
- Forwarding, combinational, per operand i:
  - 10 if ex_mem_regWrite, ex_mem_rd!=0 and ex_mem_rd==rs_i.
  - Else 01 if mem_wb_regWrite, mem_wb_rd!=0 and mem_wb_rd==rs_i.
  - Else 00.
  - EX/MEM has priority. Register 0 is never forwarded. Each operand compares only its own rs_i.
- Hazard hit: id_ex_memRead && id_ex_rd!=0 && some i with if_id_rs_used[i] && if_id_rs[i]==id_ex_rd.
- FSM states: RUN, LU_STALL. Down-counter rem is 4 bits.
- freeze = dmem_busy. It overrides everything: when freeze=1, stall=0 and bubble=0, and FSM state, rem and stall_cnt hold.
- When not frozen, a flush forces stall=bubble=0 and sets the next state to RUN with rem=0, aborting any load-use stall.
- RUN, not frozen, no flush:
  - On hit, stall=bubble=1.
  - If LOAD_USE_CYCLES>1, next state is LU_STALL with rem=LOAD_USE_CYCLES-1. Otherwise stay in RUN.
- LU_STALL, not frozen, no flush:
  - stall=bubble=1 and rem decrements.
  - Next state is RUN when rem==1.
- bubble always equals stall.
- Counters:
  - stall_cnt increments on cycles with stall=1; freeze_cnt increments on cycles with freeze=1.
  - Both saturate at all-ones.
  - cnt_clr has priority over increment; the next value is 0.

## Timing
- Reset: state RUN, rem 0, both counters 0. Outputs are then purely input-dependent; with all inputs 0 every output is 0.
- fwd_sel, stall, bubble and freeze are combinational, valid in the same cycle as their inputs.
- A load-use hazard produces exactly LOAD_USE_CYCLES stall cycles, not counting interleaved freeze cycles.
- Freeze in the middle of LU_STALL pauses the countdown; it resumes with the same rem after dmem_busy falls.
- A hit and flush in the same cycle give no stall. A hit and dmem_busy in the same cycle give freeze only; the hit is re-evaluated next cycle.
- An asynchronous reset mid-stall returns to RUN immediately, and stall drops as soon as inputs show no hit.

## Test plan
- ex_mem_rd=5, mem_wb_rd=5, both writing, id_ex_rs={5,5} -> fwd_sel=1010. Repeat with ex_mem_regWrite=0 -> 0101. Repeat with rd=0 -> 0000.
- LOAD_USE_CYCLES=1: load rd=7 in ID/EX, if_id_rs[0]=7 used -> stall=bubble=1 for one cycle, stall_cnt=1. Same case with if_id_rs_used=0 -> no stall.
- LOAD_USE_CYCLES=3: load-use hit -> stall high for exactly 3 cycles. Insert dmem_busy for 2 cycles after the first stall cycle -> freeze=1 and stall=0 for those 2 cycles, then 2 more stall cycles; stall_cnt=3, freeze_cnt=2.
- LOAD_USE_CYCLES=3: flush in the second stall cycle -> stall=0 that cycle, FSM returns to RUN, stall_cnt=1.
- CNT_W=4: hold dmem_busy 20 cycles -> freeze_cnt saturates at 15. Pulse cnt_clr -> 0 next cycle. Assert rst_n=0 mid-LU_STALL -> counters 0 and state RUN.

Source files
------------

// File: rtl/forward_hazard_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : forward_hazard_unit_if
// Description : Pipeline-side signal bundle of the forwarding/hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface forward_hazard_unit_if #(
    parameter int REG_AW = 5,
    parameter int NSRC   = 2,
    parameter int CNT_W  = 16
);
    logic                     ex_mem_regWrite;
    logic [REG_AW-1:0]        ex_mem_rd;
    logic                     mem_wb_regWrite;
    logic [REG_AW-1:0]        mem_wb_rd;
    logic [NSRC*REG_AW-1:0]   id_ex_rs;
    logic                     id_ex_memRead;
    logic [REG_AW-1:0]        id_ex_rd;
    logic [NSRC*REG_AW-1:0]   if_id_rs;
    logic [NSRC-1:0]          if_id_rs_used;
    logic                     flush;
    logic                     dmem_busy;
    logic                     cnt_clr;
    logic [2*NSRC-1:0]        fwd_sel;
    logic                     stall;
    logic                     bubble;
    logic                     freeze;
    logic [CNT_W-1:0]         stall_cnt;
    logic [CNT_W-1:0]         freeze_cnt;

    modport master (
        output ex_mem_regWrite, ex_mem_rd, mem_wb_regWrite, mem_wb_rd,
               id_ex_rs, id_ex_memRead, id_ex_rd, if_id_rs, if_id_rs_used,
               flush, dmem_busy, cnt_clr,
        input  fwd_sel, stall, bubble, freeze, stall_cnt, freeze_cnt
    );

    modport slave (
        input  ex_mem_regWrite, ex_mem_rd, mem_wb_regWrite, mem_wb_rd,
               id_ex_rs, id_ex_memRead, id_ex_rd, if_id_rs, if_id_rs_used,
               flush, dmem_busy, cnt_clr,
        output fwd_sel, stall, bubble, freeze, stall_cnt, freeze_cnt
    );
endinterface
`default_nettype wire

// File: rtl/forward_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : forward_hazard_unit
// Description : Operand forwarding, load-use stall and dmem freeze control.
// Revision    : 1.0 - initial release
// ============================================================================
module forward_hazard_unit #(
    parameter int REG_AW          = 5,
    parameter int NSRC            = 2,
    parameter int LOAD_USE_CYCLES = 1,
    parameter int CNT_W           = 16
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    forward_hazard_unit_if.slave    bus
);
    localparam logic [0:0]       c_st_run      = 1'b0;
    localparam logic [0:0]       c_st_lu_stall = 1'b1;
    localparam logic [3:0]       c_lu_rem      = 4'(LOAD_USE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_max     = '1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [3:0]       r_rem;
    logic [3:0]       w_rem_nxt;
    logic             w_stall;
    logic             w_hit;
    logic [2*NSRC-1:0] w_fwd_sel;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_freeze_cnt;

    // EX/MEM wins over MEM/WB; x0 is hard-wired zero and never forwarded.
    always_comb begin
        w_fwd_sel = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (bus.ex_mem_regWrite && (bus.ex_mem_rd != '0) &&
                (bus.ex_mem_rd == bus.id_ex_rs[i*REG_AW +: REG_AW]))
                w_fwd_sel[2*i +: 2] = 2'b10;
            else if (bus.mem_wb_regWrite && (bus.mem_wb_rd != '0) &&
                     (bus.mem_wb_rd == bus.id_ex_rs[i*REG_AW +: REG_AW]))
                w_fwd_sel[2*i +: 2] = 2'b01;
        end
    end

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (bus.if_id_rs_used[i] &&
                (bus.if_id_rs[i*REG_AW +: REG_AW] == bus.id_ex_rd))
                w_hit = 1'b1;
        end
        w_hit = w_hit && bus.id_ex_memRead && (bus.id_ex_rd != '0);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_stall     = 1'b0;
        if (bus.dmem_busy) begin
            w_state_nxt = r_state;
            w_rem_nxt   = r_rem;
        end else if (bus.flush) begin
            w_state_nxt = c_st_run;
            w_rem_nxt   = 4'd0;
        end else begin
            case (r_state)
                c_st_run: begin
                    if (w_hit) begin
                        w_stall = 1'b1;
                        if (LOAD_USE_CYCLES > 1) begin
                            w_state_nxt = c_st_lu_stall;
                            w_rem_nxt   = c_lu_rem;
                        end
                    end
                end
                c_st_lu_stall: begin
                    w_stall   = 1'b1;
                    w_rem_nxt = r_rem - 4'd1;
                    if (r_rem == 4'd1)
                        w_state_nxt = c_st_run;
                end
                default: begin
                    w_state_nxt = c_st_run;
                    w_rem_nxt   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_run;
            r_rem   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // stall is already forced low while frozen, so the stall counter holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt  <= '0;
            r_freeze_cnt <= '0;
        end else if (bus.cnt_clr) begin
            r_stall_cnt  <= '0;
            r_freeze_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != c_cnt_max))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (bus.dmem_busy && (r_freeze_cnt != c_cnt_max))
                r_freeze_cnt <= r_freeze_cnt + 1'b1;
        end
    end

    assign bus.fwd_sel    = w_fwd_sel;
    assign bus.stall      = w_stall;
    assign bus.bubble     = w_stall;
    assign bus.freeze     = bus.dmem_busy;
    assign bus.stall_cnt  = r_stall_cnt;
    assign bus.freeze_cnt = r_freeze_cnt;

endmodule
`default_nettype wire

// File: tb/tb_forward_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_forward_hazard_unit
// Description : Scoreboard bench for forward_hazard_unit (directed + random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_forward_hazard_unit;
    localparam int REG_AW = 5;
    localparam int NSRC   = 2;
    localparam int LUC    = 3;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    typedef struct {
        bit                   ex_we;
        bit [REG_AW-1:0]      ex_rd;
        bit                   mw_we;
        bit [REG_AW-1:0]      mw_rd;
        bit [NSRC*REG_AW-1:0] id_rs;
        bit                   id_ld;
        bit [REG_AW-1:0]      id_rd;
        bit [NSRC*REG_AW-1:0] if_rs;
        bit [NSRC-1:0]        if_used;
        bit                   flush;
        bit                   busy;
        bit                   clr;
        bit                   rst;
    } stim_t;

    typedef struct {
        bit [2*NSRC-1:0] fwd;
        bit              stall;
        bit              freeze;
        int              scnt;
        int              fcnt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];

    // Reference model state: stall cycles still owed, and counter values.
    int   m_pending;
    int   m_scnt;
    int   m_fcnt;

    forward_hazard_unit_if #(.REG_AW(REG_AW), .NSRC(NSRC), .CNT_W(CNT_W)) bus ();

    forward_hazard_unit #(
        .REG_AW(REG_AW), .NSRC(NSRC), .LOAD_USE_CYCLES(LUC), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    function automatic bit [2*NSRC-1:0] model_fwd(input stim_t s);
        bit [2*NSRC-1:0] f;
        bit [REG_AW-1:0] rs;
        f = '0;
        for (int i = 0; i < NSRC; i++) begin
            rs = s.id_rs[i*REG_AW +: REG_AW];
            if (s.ex_we && s.ex_rd != 0 && s.ex_rd == rs)      f[2*i +: 2] = 2'b10;
            else if (s.mw_we && s.mw_rd != 0 && s.mw_rd == rs) f[2*i +: 2] = 2'b01;
        end
        return f;
    endfunction

    function automatic bit model_hit(input stim_t s);
        bit any;
        any = 1'b0;
        for (int i = 0; i < NSRC; i++)
            if (s.if_used[i] && s.if_rs[i*REG_AW +: REG_AW] == s.id_rd) any = 1'b1;
        return any && s.id_ld && (s.id_rd != 0);
    endfunction

    task automatic apply(input stim_t s);
        exp_t e;
        int   pend;
        @(posedge clk);
        #1;
        bus.ex_mem_regWrite = s.ex_we;
        bus.ex_mem_rd       = s.ex_rd;
        bus.mem_wb_regWrite = s.mw_we;
        bus.mem_wb_rd       = s.mw_rd;
        bus.id_ex_rs        = s.id_rs;
        bus.id_ex_memRead   = s.id_ld;
        bus.id_ex_rd        = s.id_rd;
        bus.if_id_rs        = s.if_rs;
        bus.if_id_rs_used   = s.if_used;
        bus.flush           = s.flush;
        bus.dmem_busy       = s.busy;
        bus.cnt_clr         = s.clr;
        rst_n               = !s.rst;
        if (s.rst) begin
            m_pending = 0;
            m_scnt    = 0;
            m_fcnt    = 0;
        end
        pend     = m_pending;
        e.fwd    = model_fwd(s);
        e.freeze = s.busy;
        e.stall  = 1'b0;
        if (s.busy) begin
        end else if (s.flush) begin
            pend = 0;
        end else if (pend > 0) begin
            e.stall = 1'b1;
            pend--;
        end else if (model_hit(s)) begin
            e.stall = 1'b1;
            pend    = LUC - 1;
        end
        e.scnt = m_scnt;
        e.fcnt = m_fcnt;
        sb.push_back(e);
        if (!s.rst) begin
            m_pending = pend;
            if (s.clr) begin
                m_scnt = 0;
                m_fcnt = 0;
            end else begin
                if (e.stall && m_scnt < CMAX)  m_scnt++;
                if (e.freeze && m_fcnt < CMAX) m_fcnt++;
            end
        end
    endtask

    // Monitor: outputs are combinational, so each cycle presents one response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("fwd_sel",    bus.fwd_sel,    e.fwd);
                chk("stall",      bus.stall,      e.stall);
                chk("bubble",     bus.bubble,     e.stall);
                chk("freeze",     bus.freeze,     e.freeze);
                chk("stall_cnt",  bus.stall_cnt,  e.scnt);
                chk("freeze_cnt", bus.freeze_cnt, e.fcnt);
            end
        end
    end

    initial begin
        stim_t s;
        stim_t hit;
        int    waited;
        n_tests   = 0;
        n_fail    = 0;
        m_pending = 0;
        m_scnt    = 0;
        m_fcnt    = 0;
        rst_n     = 1'b0;
        bus.ex_mem_regWrite = 1'b0; bus.ex_mem_rd = '0;
        bus.mem_wb_regWrite = 1'b0; bus.mem_wb_rd = '0;
        bus.id_ex_rs = '0; bus.id_ex_memRead = 1'b0; bus.id_ex_rd = '0;
        bus.if_id_rs = '0; bus.if_id_rs_used = '0;
        bus.flush = 1'b0; bus.dmem_busy = 1'b0; bus.cnt_clr = 1'b0;

        s = '{default: 0};
        s.rst = 1'b1;
        apply(s);
        apply(s);
        s.rst = 1'b0;
        apply(s);

        // Forwarding priority, disable and register-0 cases.
        s.ex_we = 1; s.ex_rd = 5; s.mw_we = 1; s.mw_rd = 5; s.id_rs = {5'd5, 5'd5};
        apply(s);
        s.ex_we = 0;
        apply(s);
        s.ex_we = 1; s.ex_rd = 0; s.mw_rd = 0;
        apply(s);
        s = '{default: 0};
        s.ex_we = 1; s.ex_rd = 3; s.mw_we = 1; s.mw_rd = 9; s.id_rs = {5'd9, 5'd3};
        apply(s);

        // Load-use: plain, with freeze in the middle, with flush, unused operand.
        hit = '{default: 0};
        hit.id_ld = 1; hit.id_rd = 7; hit.if_rs = {5'd0, 5'd7}; hit.if_used = 2'b01;
        apply(hit);
        s = '{default: 0};
        apply(s); apply(s); apply(s); apply(s);
        apply(hit);
        s.busy = 1;
        apply(s); apply(s);
        s.busy = 0;
        apply(s); apply(s); apply(s);
        apply(hit);
        s.flush = 1;
        apply(s);
        s.flush = 0;
        apply(s); apply(s);
        hit.if_used = 2'b00;
        apply(hit);
        hit.if_used = 2'b10; hit.if_rs = {5'd7, 5'd1};
        apply(hit);
        apply(s); apply(s); apply(s);

        // Freeze counter saturation, then clear.
        s.busy = 1;
        repeat (20) apply(s);
        s.busy = 0; s.clr = 1;
        apply(s);
        s.clr = 0;
        apply(s);

        // Asynchronous reset in the middle of a load-use stall.
        hit.if_used = 2'b01; hit.if_rs = {5'd0, 5'd7};
        apply(hit);
        s.rst = 1;
        apply(s);
        apply(hit);
        s.rst = 0;
        apply(s); apply(s); apply(s);

        // Randomized traffic on a small register space so matches are frequent.
        for (int n = 0; n < 3000; n++) begin
            s.ex_we   = 1'($urandom_range(0, 1));
            s.ex_rd   = 5'($urandom_range(0, 3));
            s.mw_we   = 1'($urandom_range(0, 1));
            s.mw_rd   = 5'($urandom_range(0, 3));
            s.id_rs   = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            s.id_ld   = 1'($urandom_range(0, 1));
            s.id_rd   = 5'($urandom_range(0, 3));
            s.if_rs   = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            s.if_used = 2'($urandom_range(0, 3));
            s.flush   = ($urandom_range(0, 9) == 0);
            s.busy    = ($urandom_range(0, 4) == 0);
            s.clr     = ($urandom_range(0, 39) == 0);
            s.rst     = ($urandom_range(0, 99) == 0);
            apply(s);
        end
        s = '{default: 0};
        apply(s);

        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain actual=%0d expected=0 pending responses", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
